silent_step_filter: RTL and testbench
=====================================

Name: silent_step_filter

Overview:
Downstream of seq_operator and upstream of the PWM/transducer drive stage. Consumes per-transducer DUTY/PHASE targets and produces rate-limited outputs so that abrupt changes do not cause audible noise (silent mode). On each synchronizer UPDATE tick it sweeps all transducers, one per clock. Each output moves toward its target by at most STEP: duty by saturating linear steps, phase by the shortest path around the 8-bit circle.

Parameters:
TRANS_NUM, 249, number of transducers (array depth, sweep length).

Ports:
CLK  in  1  system clock (ultrasound_cnt_clk_gen clk_out1).
RST_N  in  1  reset; one clock; synchronous, active-low.
UPDATE  in  1  single-cycle tick from synchronizer; starts a sweep.
SILENT  in  1  1 = rate-limit, 0 = pass target straight through; from config_manager.
STEP  in  8  maximum change per sweep, unsigned.
DUTY  in  8 x TRANS_NUM  target duty from seq_operator.
PHASE  in  8 x TRANS_NUM  target phase from seq_operator.
DUTY_OUT  out  8 x TRANS_NUM  filtered duty, registered.
PHASE_OUT  out  8 x TRANS_NUM  filtered phase, registered.
BUSY  out  1  high while a sweep is in progress.
DONE  out  1  one-cycle pulse after the last element is written.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - All DUTY_OUT/PHASE_OUT = 0; BUSY = 0; DONE = 0; pending = 0; idx = 0; state = IDLE.
  - Reset mid-sweep aborts immediately; no partial write is completed.
- FSM states: IDLE, RUN, FIN.
  - IDLE: UPDATE high at edge k -> RUN from k+1, idx = 0.
  - RUN: element idx is written at each edge; idx increments. After writing idx = TRANS_NUM-1 -> FIN.
  - FIN (one cycle): DONE = 1. Next state is RUN (idx = 0, pending cleared) if pending = 1, else IDLE.
- Timing: with UPDATE at edge k, element i is written at edge k+1+i. BUSY is high for cycles k+1 .. k+TRANS_NUM. DONE is high in cycle k+TRANS_NUM+1.
- Overlapping updates: UPDATE seen in RUN or FIN sets pending (a single bit; multiple ticks collapse into one). An UPDATE in IDLE while pending = 0 starts normally.
- Sampling: DUTY[idx], PHASE[idx], SILENT and STEP are sampled live on the cycle element idx is processed. There is no snapshot; a SILENT change mid-sweep applies from the next element onward.
- SILENT = 0: out <= target for both duty and phase.
- SILENT = 1, duty (unsigned, current c, target t, step s):
  - if |t - c| <= s: out <= t;
  - else: out <= c + s (t > c) or c - s (t < c).
  - No overflow is possible; compute in 9 bits.
- SILENT = 1, phase:
  - d = (t - c) mod 256, interpreted as 8-bit signed.
  - if |d| <= s: out <= t;
  - else: out <= (c + s) mod 256 (d > 0) or (c - s) mod 256 (d < 0).
  - d = -128 (0x80) steps in the positive direction.
  - |d| is computed in 9 bits so that |-128| = 128.
- STEP = 0 is treated as STEP = 1, so outputs always converge.
- STEP >= 128 makes phase reach its target in one sweep. STEP = 255 makes duty reach its target in one sweep.
- Elements not at the current idx hold their value.

Decomposition:
- Package silent_pkg:
  - typedef enum logic [1:0] state_t {IDLE, RUN, FIN};
  - localparam STEP_MIN = 8'd1;
  - function wrap_diff8 (signed circular difference).
- Sub-module step_limiter: purely combinational. Inputs cur, tgt, step, circular (0 = duty, 1 = phase), bypass. Output nxt (8 bits). Instantiated twice (duty, phase) on the idx-selected element.
- The top level holds the FSM, idx counter, pending flag and output arrays.

Test Plan:
- Reset/pass-through: RST_N low 2 cycles -> all outputs 0, BUSY = 0. Then SILENT = 0, DUTY[0] = 0x11, PHASE[248] = 0x44, one UPDATE -> DUTY_OUT[0] = 0x11 at edge k+1, PHASE_OUT[248] = 0x44 at edge k+249, DONE pulse at cycle k+250, BUSY high exactly 249 cycles.
- Duty slew: SILENT = 1, STEP = 16, DUTY[0] 0 -> 0xFF, repeated UPDATEs -> DUTY_OUT[0] reads 16, 32, ..., 240, then 255, then stays 255. Target dropped to 0x08 -> 239, 223, ... until 8.
- Phase wrap: SILENT = 1, STEP = 10, cur 0xF8, target 0x05 -> 0x02, then 0x05 (forward through 0). Cur 0x05, target 0xF8 -> 0xFB, then 0xF8. Cur 0x00, target 0x80 -> 0x0A (positive direction).
- Overlap: UPDATE at k, then at k+10 and k+100 -> exactly one extra sweep, second BUSY starting at k+TRANS_NUM+2, two DONE pulses total.
- Mid-sweep reset: RST_N low at k+100 for one cycle -> outputs 0, state IDLE. No DONE pulse; the next UPDATE sweeps normally from idx 0.
- Edge steps: STEP = 0, duty 0 -> 3 -> 1, 2, 3 over three sweeps. STEP = 255, duty 0 -> 0xFF and phase 0x00 -> 0x80 -> both reach target in one sweep.

Source files
------------

// File: rtl/silent_step_filter_pkg.sv
// Shared types and helpers for the silent-mode step filter.
package silent_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [7:0] STEP_MIN = 8'd1;

    // Signed distance from cur to tgt around the 8-bit phase circle.
    function automatic logic signed [7:0] wrap_diff8(input logic [7:0] tgt, input logic [7:0] cur);
        logic [7:0] diff;
        diff = tgt - cur;
        return $signed(diff);
    endfunction

endpackage

// File: rtl/silent_step_filter_step_limiter.sv
// Moves one 8-bit value toward its target by at most one step, linearly or around the circle.
module step_limiter
    import silent_pkg::*;
(
    input  logic [7:0] cur,
    input  logic [7:0] tgt,
    input  logic [7:0] step,
    input  logic       circular,
    input  logic       bypass,
    output logic [7:0] nxt
);

    logic [7:0]        step_eff;
    logic [8:0]        lin_mag;
    logic              lin_up;
    logic signed [7:0] circ_d;
    logic [8:0]        circ_mag;
    logic              circ_up;
    logic [8:0]        mag;
    logic              up;

    always_comb begin
        step_eff = (step == 8'd0) ? STEP_MIN : step;

        lin_up  = (tgt >= cur);
        lin_mag = lin_up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});

        // Half-way round (0x80) resolves in the positive direction.
        circ_d   = wrap_diff8(tgt, cur);
        circ_up  = !circ_d[7] || (circ_d == -8'sd128);
        circ_mag = circ_d[7] ? (9'd256 - {1'b0, circ_d}) : {1'b0, circ_d};

        mag = circular ? circ_mag : lin_mag;
        up  = circular ? circ_up : lin_up;

        if (bypass || (mag <= {1'b0, step_eff})) begin
            nxt = tgt;
        end else if (up) begin
            nxt = cur + step_eff;
        end else begin
            nxt = cur - step_eff;
        end
    end

endmodule

// File: rtl/silent_step_filter.sv
// Rate-limits per-transducer duty/phase targets, sweeping one element per clock on each UPDATE.
module silent_step_filter
    import silent_pkg::*;
#(
    parameter int TRANS_NUM = 249
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   UPDATE,
    input  logic                   SILENT,
    input  logic [7:0]             STEP,
    input  logic [8*TRANS_NUM-1:0] DUTY,
    input  logic [8*TRANS_NUM-1:0] PHASE,
    output logic [8*TRANS_NUM-1:0] DUTY_OUT,
    output logic [8*TRANS_NUM-1:0] PHASE_OUT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [1:0]             STATE_DBG
);

    localparam int IDX_W = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRANS_NUM - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pending_q, pending_d;
    logic             wr_en;
    logic [7:0]       duty_q  [TRANS_NUM];
    logic [7:0]       phase_q [TRANS_NUM];
    logic [IDX_W+2:0] sel_base;
    logic [7:0]       duty_nxt, phase_nxt;

    assign sel_base  = {idx_q, 3'b000};
    assign STATE_DBG = state_q;

    step_limiter u_duty_lim (
        .cur      (duty_q[idx_q]),
        .tgt      (DUTY[sel_base +: 8]),
        .step     (STEP),
        .circular (1'b0),
        .bypass   (!SILENT),
        .nxt      (duty_nxt)
    );

    step_limiter u_phase_lim (
        .cur      (phase_q[idx_q]),
        .tgt      (PHASE[sel_base +: 8]),
        .step     (STEP),
        .circular (1'b1),
        .bypass   (!SILENT),
        .nxt      (phase_nxt)
    );

    // Ticks arriving during RUN/FIN collapse into one pending re-sweep.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        wr_en     = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state_q)
            IDLE: begin
                if (UPDATE || pending_q) begin
                    state_d   = RUN;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            RUN: begin
                BUSY  = 1'b1;
                wr_en = 1'b1;
                if (UPDATE) begin
                    pending_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            FIN: begin
                DONE = 1'b1;
                if (pending_q || UPDATE) begin
                    state_d   = RUN;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            for (int i = 0; i < TRANS_NUM; i++) begin
                duty_q[i]  <= 8'd0;
                phase_q[i] <= 8'd0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            if (wr_en) begin
                duty_q[idx_q]  <= duty_nxt;
                phase_q[idx_q] <= phase_nxt;
            end
        end
    end

    for (genvar g = 0; g < TRANS_NUM; g++) begin : g_out
        assign DUTY_OUT[8*g +: 8]  = duty_q[g];
        assign PHASE_OUT[8*g +: 8] = phase_q[g];
    end

endmodule

// File: tb/tb_silent_step_filter.sv
// Directed bench for silent_step_filter with a per-sweep expected-value scoreboard.
module tb_silent_step_filter;
    import silent_pkg::*;

    localparam int TN = 249;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          update;
    logic          silent;
    logic [7:0]    step;
    logic [8*TN-1:0] duty_v, phase_v;
    logic [8*TN-1:0] duty_out, phase_out;
    logic          busy, done;
    logic [1:0]    state_dbg;

    int n_assert = 0;
    int n_fail   = 0;
    int busy_seen = 0;
    int done_seen = 0;

    logic [7:0] mdl_d [TN];
    logic [7:0] mdl_p [TN];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    silent_step_filter #(.TRANS_NUM(TN)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .UPDATE    (update),
        .SILENT    (silent),
        .STEP      (step),
        .DUTY      (duty_v),
        .PHASE     (phase_v),
        .DUTY_OUT  (duty_out),
        .PHASE_OUT (phase_out),
        .BUSY      (busy),
        .DONE      (done),
        .STATE_DBG (state_dbg)
    );

    always @(negedge clk) begin
        busy_seen <= busy_seen + ((busy === 1'b1) ? 1 : 0);
        done_seen <= done_seen + ((done === 1'b1) ? 1 : 0);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] get_d(input int i);
        return duty_out[8*i +: 8];
    endfunction

    function automatic logic [7:0] get_p(input int i);
        return phase_out[8*i +: 8];
    endfunction

    function automatic logic [7:0] model_duty(input int c, input int t, input int s);
        int se;
        int diff;
        se = (s == 0) ? 1 : s;
        diff = t - c;
        if (diff <= se && diff >= -se) return 8'(t);
        if (diff > 0) return 8'(c + se);
        return 8'(c - se);
    endfunction

    function automatic logic [7:0] model_phase(input int c, input int t, input int s);
        int se;
        int d;
        se = (s == 0) ? 1 : s;
        d = (((t - c) % 256) + 256) % 256;
        if (d >= 128) d = d - 256;
        if (d <= se && d >= -se) return 8'(t);
        if (d > 0 || d == -128) return 8'((c + se) % 256);
        return 8'((c - se + 256) % 256);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic randomize_targets();
        for (int i = 0; i < TN; i++) begin
            duty_v[8*i +: 8]  = 8'($urandom_range(0, 255));
            phase_v[8*i +: 8] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < TN; i++) begin
            mdl_d[i] = 8'd0;
            mdl_p[i] = 8'd0;
        end
        exp_q.delete();
    endtask

    task automatic push_expect();
        for (int i = 0; i < TN; i++) begin
            if (silent) begin
                mdl_d[i] = model_duty(int'(mdl_d[i]), int'(duty_v[8*i +: 8]), int'(step));
                mdl_p[i] = model_phase(int'(mdl_p[i]), int'(phase_v[8*i +: 8]), int'(step));
            end else begin
                mdl_d[i] = duty_v[8*i +: 8];
                mdl_p[i] = phase_v[8*i +: 8];
            end
            exp_q.push_back(mdl_d[i]);
            exp_q.push_back(mdl_p[i]);
        end
    endtask

    task automatic check_sweep(input string tag);
        logic [7:0] e;
        for (int i = 0; i < TN; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_duty[%0d]", tag, i), get_d(i), e);
            e = exp_q.pop_front();
            check($sformatf("%s_phase[%0d]", tag, i), get_p(i), e);
        end
    endtask

    task automatic pulse_update();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_int({tag, "_done_seen"}, int'(done === 1'b1), 1);
    endtask

    task automatic sweep(input string tag);
        int n;
        push_expect();
        pulse_update();
        wait_done(tag, n);
        check_sweep(tag);
    endtask

    initial begin
        int n;
        int b0;
        int d0;
        rst_n  = 1'b0;
        update = 1'b0;
        silent = 1'b0;
        step   = 8'd0;
        randomize_targets();

        // Reset state
        do_reset();
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_state", int'(state_dbg), int'(IDLE));
        check_int("rst_duty_or", int'(|duty_out), 0);
        check_int("rst_phase_or", int'(|phase_out), 0);

        // Pass-through with timing
        silent = 1'b0;
        step = 8'($urandom_range(1, 255));
        duty_v[0 +: 8] = 8'h11;
        phase_v[8*248 +: 8] = 8'h44;
        push_expect();
        b0 = busy_seen;
        d0 = done_seen;
        pulse_update();
        check_int("pt_busy_start", int'(busy), 1);
        check("pt_duty0_before", get_d(0), 8'h00);
        @(negedge clk);
        check("pt_duty0_k1", get_d(0), 8'h11);
        wait_done("pt", n);
        check_int("pt_done_latency", n, 248);
        check("pt_phase248", get_p(248), 8'h44);
        check_int("pt_busy_cycles", busy_seen - b0, 249);
        check_sweep("pt");
        @(negedge clk);
        check_int("pt_done_pulse_end", int'(done), 0);
        check_int("pt_busy_end", int'(busy), 0);
        check_int("pt_done_count", done_seen - d0, 1);

        // Duty slew up then down
        do_reset();
        randomize_targets();
        silent = 1'b1;
        step = 8'd16;
        duty_v[0 +: 8] = 8'hFF;
        for (int j = 0; j < 17; j++) begin
            sweep("slew_up");
            check("slew_up_d0", get_d(0), (j < 15) ? 8'(16 * (j + 1)) : 8'hFF);
        end
        duty_v[0 +: 8] = 8'h08;
        for (int j = 0; j < 17; j++) begin
            sweep("slew_dn");
            check("slew_dn_d0", get_d(0), (255 - 16 * (j + 1) > 8) ? 8'(255 - 16 * (j + 1)) : 8'h08);
        end

        // Phase wrap around the circle
        silent = 1'b0;
        phase_v[8*5 +: 8] = 8'hF8;
        sweep("ph_load");
        silent = 1'b1;
        step = 8'd10;
        phase_v[8*5 +: 8] = 8'h05;
        sweep("ph_fwd1");
        check("ph_fwd1_p5", get_p(5), 8'h02);
        sweep("ph_fwd2");
        check("ph_fwd2_p5", get_p(5), 8'h05);
        phase_v[8*5 +: 8] = 8'hF8;
        sweep("ph_bwd1");
        check("ph_bwd1_p5", get_p(5), 8'hFB);
        sweep("ph_bwd2");
        check("ph_bwd2_p5", get_p(5), 8'hF8);
        silent = 1'b0;
        phase_v[8*5 +: 8] = 8'h00;
        sweep("ph_zero");
        silent = 1'b1;
        phase_v[8*5 +: 8] = 8'h80;
        sweep("ph_half");
        check("ph_half_p5", get_p(5), 8'h0A);

        // Overlapping updates collapse into one extra sweep
        do_reset();
        randomize_targets();
        silent = 1'b1;
        step = 8'($urandom_range(1, 40));
        push_expect();
        b0 = busy_seen;
        d0 = done_seen;
        pulse_update();
        repeat (9) @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (89) @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_done("ovl1", n);
        check_sweep("ovl1");
        push_expect();
        @(negedge clk);
        check_int("ovl_second_busy", int'(busy), 1);
        wait_done("ovl2", n);
        check_sweep("ovl2");
        repeat (300) @(negedge clk);
        check_int("ovl_done_count", done_seen - d0, 2);
        check_int("ovl_busy_cycles", busy_seen - b0, 2 * TN);
        check_int("ovl_state_idle", int'(state_dbg), int'(IDLE));

        // Reset in the middle of a sweep
        randomize_targets();
        silent = 1'b0;
        d0 = done_seen;
        pulse_update();
        repeat (98) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_int("mid_rst_busy", int'(busy), 0);
        check_int("mid_rst_done", int'(done), 0);
        check_int("mid_rst_state", int'(state_dbg), int'(IDLE));
        check_int("mid_rst_duty_or", int'(|duty_out), 0);
        check_int("mid_rst_phase_or", int'(|phase_out), 0);
        for (int i = 0; i < TN; i++) begin
            mdl_d[i] = 8'd0;
            mdl_p[i] = 8'd0;
        end
        repeat (300) @(negedge clk);
        check_int("mid_rst_no_done", done_seen - d0, 0);
        sweep("post_rst");

        // STEP = 0 behaves as 1; STEP = 255 reaches target in one sweep
        do_reset();
        randomize_targets();
        silent = 1'b1;
        step = 8'd0;
        duty_v[0 +: 8] = 8'h03;
        for (int j = 0; j < 3; j++) begin
            sweep("step0");
            check("step0_d0", get_d(0), 8'(j + 1));
        end
        do_reset();
        randomize_targets();
        step = 8'd255;
        duty_v[0 +: 8] = 8'hFF;
        phase_v[0 +: 8] = 8'h80;
        sweep("step255");
        check("step255_d0", get_d(0), 8'hFF);
        check("step255_p0", get_p(0), 8'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
